// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module  : nibble_serial_adder_pkg
// Brief   : Shared constants for the nibble-serial adder: slice width, state
//           encodings and the counter-width helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

  localparam int c_NIB_BITS = 4;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // A single-nibble operand still needs a 1-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_nibble_slice.sv
// ============================================================================
// Module  : cla_nibble_slice
// Brief   : Purely combinational 4-bit generate/propagate carry-look-ahead adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic [4:1] c
);

  logic [3:0] w_g;
  logic [3:0] w_p;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign c[1] = w_g[0] | (w_p[0] & cin);
  assign c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ {c[3:1], cin};

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module  : nibble_serial_adder
// Brief   : WIDTH-bit adder streaming 4 bits per cycle through one CLA slice,
//           valid/ready on both sides. OVF_FLAG_EN adds a signed overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int NIB = WIDTH / c_NIB_BITS;
  localparam int CW  = cnt_width(NIB);

  if (((WIDTH % c_NIB_BITS) != 0) || (WIDTH < c_NIB_BITS)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_last;
  logic [3:0]       w_slice_sum;
  logic [4:1]       w_slice_c;
  logic             w_unused_c;

  cla_nibble_slice u_slice (
    .a   (r_a_sh[3:0]),
    .b   (r_b_sh[3:0]),
    .cin (r_carry),
    .sum (w_slice_sum),
    .c   (w_slice_c)
  );

  assign w_unused_c = ^w_slice_c[3:1];
  assign w_last     = (r_cnt == CW'(NIB - 1));

  if (WIDTH == c_NIB_BITS) begin : g_sum_single
    assign w_sum_next = w_slice_sum;
  end else begin : g_sum_shift
    assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:c_NIB_BITS]};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: if (in_valid) w_next = c_ST_RUN;
      c_ST_RUN:  if (w_last)   w_next = c_ST_DONE;
      c_ST_DONE: if (out_ready) w_next = c_ST_IDLE;
      default:   w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_ST_IDLE);
    out_valid = (r_state == c_ST_DONE);
  end

  // Low nibble enters first; each slice result lands at the top and drifts down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        c_ST_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_c[4];
          r_a_sh  <= r_a_sh >> c_NIB_BITS;
          r_b_sh  <= r_b_sh >> c_NIB_BITS;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_cout <= w_slice_c[4];
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst)                                r_ovf <= 1'b0;
    else if ((r_state == c_ST_RUN) && w_last) r_ovf <= w_slice_c[3] ^ w_slice_c[4];
  end

  assign overflow = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module  : tb_nibble_serial_adder
// Brief   : Directed vectors for nibble_serial_adder with a cycle-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef OVF_FLAG_EN
    ,
    .overflow  (ovf)
`endif
  );

`ifndef OVF_FLAG_EN
  assign ovf = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy for NIB cycles after acceptance, then holds
  // the arithmetic result until the consumer takes it.
  bit           m_live = 0;
  bit           m_idle = 1;
  bit           m_done = 0;
  int           m_left = 0;
  logic [W:0]   m_res;
  bit           m_res_ovf;
  logic [W-1:0] m_sum;
  bit           m_cout;
  bit           m_ovf;

  always @(posedge clk) begin
    m_live <= 1'b1;
    if (rst) begin
      m_idle = 1; m_done = 0; m_left = 0;
      m_sum = '0; m_cout = 0; m_ovf = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        int s;
        m_res     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s         = int'($signed(a)) + int'($signed(b)) + int'(cin);
        m_res_ovf = (s > 32767) || (s < -32768);
        m_idle    = 0;
        m_left    = NIB;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_sum  = m_res[W-1:0];
        m_cout = m_res[W];
        m_ovf  = m_res_ovf;
        m_done = 1;
      end
    end else if (m_done && out_ready) begin
      m_done = 0;
      m_idle = 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, m_idle});
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_done});
      if (m_done) begin
        chk("model_sum", {16'd0, sum}, {16'd0, m_sum});
        chk("model_cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef OVF_FLAG_EN
        chk("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  // Returns number of edges from the accepting edge (counted as 1) to the
  // edge after which out_valid is first seen.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    if (edges >= 100) chk("valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic [W-1:0] es, input logic ec,
                       input logic eo, input int hold);
    int edges;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = (hold == 0);
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    wait_valid(edges);
    chk({name, "_latency"}, edges, NIB + 1);
    chk({name, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef OVF_FLAG_EN
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) chk({name, "_ovf_x"}, 32'd1, 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({name, "_hold_sum"}, {16'd0, sum}, {16'd0, es});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int gap;
    int edges;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op("bp",     16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 3);

    // Reset during the second RUN cycle discards the operation.
    a = 16'h5A5A; b = 16'hA5A5; cin = 1'b1; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    do_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

    // Back-to-back: in_valid stays high with a second operand pair queued.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    a = 16'hABCD; b = 16'h1234;
    wait_valid(edges);
    chk("b2b_first_sum", {16'd0, sum}, 32'h0000_3333);
    gap = edges - 1;
    while (!in_ready && gap < 100) begin
      @(posedge clk); #1; gap++;
    end
    chk("b2b_gap", gap + 1, NIB + 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(edges);
    chk("b2b_second_sum", {16'd0, sum}, 32'h0000_BE01);
    chk("b2b_second_cout", {31'd0, cout}, 32'd0);
    @(posedge clk); #1;

    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
